// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: req/ack data bus between the memory-access stage and memory
// Signals: bus_req_o, bus_we_o, bus_addr_o (word aligned), bus_sel_o (byte lanes),
//          bus_wdata_o driven by the master; bus_ack_i, bus_rdata_i driven by the slave.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req_o;
    logic              bus_we_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [3:0]        bus_sel_o;
    logic [31:0]       bus_wdata_o;
    logic              bus_ack_i;
    logic [31:0]       bus_rdata_i;
    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
        input  bus_ack_i, bus_rdata_i
    );
    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
        output bus_ack_i, bus_rdata_i
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store stage turning micro-ops into req/ack bus transactions
// Ports: clk, rst (sync, active-high); execute side valid_i, mem_op_i, addr_i,
//        store_data_i, wd_i, wreg_i, wdata_i; stall_o back to upstream; registered
//        write-back valid_o, wd_o, wreg_o, wdata_o plus align_err_o / bus_err_o pulses;
//        bus: master side of the data bus (req/we/addr/sel/wdata out, ack/rdata in).
module mem_access_unit #(
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [3:0]            mem_op_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [31:0]           store_data_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [31:0]           wdata_i,
    output logic                  stall_o,
    output logic                  valid_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [31:0]           wdata_o,
    output logic                  align_err_o,
    output logic                  bus_err_o,
    mem_access_unit_if.master     bus
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [3:0]            op_q, op_d;
    logic [1:0]            off_q, off_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [3:0]            sel_q, sel_d;
    logic                  we_q, we_d;
    logic [31:0]           bwdata_q, bwdata_d;
    logic                  valid_q, valid_d;
    logic [REG_ADDR_W-1:0] wd_q, wd_d;
    logic                  wreg_q, wreg_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  aerr_q, aerr_d;
    logic                  berr_q, berr_d;

    logic [1:0]  a;
    logic        is_b, is_h, is_w, is_st, is_mem, aligned, accept, misal, expired;
    logic [3:0]  sel_in;
    logic [31:0] wdata_in, sh, ld_data;

    assign a        = addr_i[1:0];
    assign is_b     = mem_op_i == 4'd1 || mem_op_i == 4'd2 || mem_op_i == 4'd9;
    assign is_h     = mem_op_i == 4'd3 || mem_op_i == 4'd4 || mem_op_i == 4'd10;
    assign is_w     = mem_op_i == 4'd5 || mem_op_i == 4'd11;
    assign is_st    = mem_op_i == 4'd9 || mem_op_i == 4'd10 || mem_op_i == 4'd11;
    assign is_mem   = is_b | is_h | is_w;
    assign aligned  = is_b | (is_h & ~a[0]) | (is_w & (a == 2'd0));
    assign accept   = state_q == IDLE && valid_i && aligned;
    assign misal    = state_q == IDLE && valid_i && is_mem && !aligned;
    assign sel_in   = is_b ? 4'b0001 << a : is_h ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata_in = is_b ? {4{store_data_i[7:0]}} : is_h ? {2{store_data_i[15:0]}} : store_data_i;

    // Timeout fires on the last permitted wait cycle; TIMEOUT = 0 never fires.
    assign expired  = TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1);

    // Bring the addressed lane(s) down to bit 0, then extend per the latched op.
    assign sh       = bus.bus_rdata_i >> {off_q, 3'b000};
    assign ld_data  = op_q == 4'd1 ? {{24{sh[7]}}, sh[7:0]} :
                      op_q == 4'd2 ? {24'd0, sh[7:0]} :
                      op_q == 4'd3 ? {{16{sh[15]}}, sh[15:0]} :
                      op_q == 4'd4 ? {16'd0, sh[15:0]} : sh;

    assign stall_o         = accept || state_q == BUS;
    assign bus.bus_req_o   = state_q == BUS;
    assign bus.bus_we_o    = we_q;
    assign bus.bus_addr_o  = addr_q;
    assign bus.bus_sel_o   = sel_q;
    assign bus.bus_wdata_o = bwdata_q;
    assign valid_o         = valid_q;
    assign wd_o            = wd_q;
    assign wreg_o          = wreg_q;
    assign wdata_o         = wdata_q;
    assign align_err_o     = aerr_q;
    assign bus_err_o       = berr_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        off_d    = off_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        we_d     = we_q;
        bwdata_d = bwdata_q;
        valid_d  = 1'b0;
        wd_d     = wd_q;
        wreg_d   = wreg_q;
        wdata_d  = wdata_q;
        aerr_d   = 1'b0;
        berr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = BUS;
                    cnt_d    = '0;
                    op_d     = mem_op_i;
                    off_d    = a;
                    addr_d   = {addr_i[ADDR_W-1:2], 2'b00};
                    sel_d    = sel_in;
                    we_d     = is_st;
                    bwdata_d = wdata_in;
                end else if (misal) begin
                    valid_d = 1'b1;
                    wd_d    = wd_i;
                    wreg_d  = 1'b0;
                    aerr_d  = 1'b1;
                end else begin
                    valid_d = valid_i;
                    wd_d    = wd_i;
                    wreg_d  = wreg_i;
                    wdata_d = wdata_i;
                end
            end
            BUS: begin
                // Inputs are held stable by stall_o, so wd_i/wreg_i are still this op's.
                if (bus.bus_ack_i) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    wd_d    = wd_i;
                    wreg_d  = we_q ? 1'b0 : wreg_i;
                    wdata_d = we_q ? wdata_q : ld_data;
                end else if (expired) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    wd_d    = wd_i;
                    wreg_d  = 1'b0;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            off_q    <= '0;
            addr_q   <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            bwdata_q <= '0;
            valid_q  <= 1'b0;
            wd_q     <= '0;
            wreg_q   <= 1'b0;
            wdata_q  <= '0;
            aerr_q   <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            off_q    <= off_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            bwdata_q <= bwdata_d;
            valid_q  <= valid_d;
            wd_q     <= wd_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
            aerr_q   <= aerr_d;
            berr_q   <= berr_d;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed plus randomized checks of mem_access_unit against a behavioural model
module tb_mem_access_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, wreg_i, stall_o, valid_o, wreg_o, align_err_o, bus_err_o;
    logic [3:0]  mem_op_i;
    logic [31:0] addr_i, store_data_i, wdata_i, wdata_o;
    logic [4:0]  wd_i, wd_o;
    int          compared = 0;
    int          mismatched = 0;

    mem_access_unit_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(.ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .mem_op_i(mem_op_i), .addr_i(addr_i),
        .store_data_i(store_data_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .stall_o(stall_o), .valid_o(valid_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .align_err_o(align_err_o), .bus_err_o(bus_err_o), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Access size in bytes; 0 means the code is not a memory op.
    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd9: return 1;
            4'd3, 4'd4, 4'd10: return 2;
            4'd5, 4'd11: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] exp_sel(input logic [3:0] op, input logic [31:0] addr);
        int n = op_size(op);
        return 32'(((1 << n) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [3:0] op, input logic [31:0] sd);
        int n = op_size(op);
        longint v = longint'(sd) % (longint'(1) << (8 * n));
        longint rep = n == 1 ? 64'h01010101 : n == 2 ? 64'h00010001 : 64'h1;
        longint r = v * rep;
        return r[31:0];
    endfunction

    function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rd);
        int n = op_size(op);
        longint v = (longint'(rd) >> (8 * (addr % 4))) % (longint'(1) << (8 * n));
        if ((op == 4'd1 || op == 4'd3) && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic none_op(input logic v, input logic [3:0] op, input logic [4:0] wd, input logic wr, input logic [31:0] wdat);
        valid_i = v; mem_op_i = op; wd_i = wd; wreg_i = wr; wdata_i = wdat;
        addr_i = $urandom; store_data_i = $urandom;
        bus.bus_ack_i = 1'($urandom_range(0, 1)); bus.bus_rdata_i = $urandom;
        #1 chk("none_stall", stall_o, 0);
        @(negedge clk);
        chk("none_valid", valid_o, v);
        chk("none_wd", wd_o, wd);
        chk("none_wreg", wreg_o, wr);
        chk("none_wdata", wdata_o, wdat);
        chk("none_req", bus.bus_req_o, 0);
    endtask

    task automatic misal_op(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] wd);
        valid_i = 1'b1; mem_op_i = op; addr_i = addr; wd_i = wd; wreg_i = 1'b1;
        wdata_i = $urandom; store_data_i = $urandom; bus.bus_ack_i = 1'b0;
        #1 chk("mis_stall", stall_o, 0);
        @(negedge clk);
        chk("mis_aerr", align_err_o, 1);
        chk("mis_valid", valid_o, 1);
        chk("mis_wreg", wreg_o, 0);
        chk("mis_req", bus.bus_req_o, 0);
        chk("mis_berr", bus_err_o, 0);
    endtask

    task automatic mem_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                          input logic [31:0] rd, input int dly, input logic [4:0] wd, input logic wr);
        logic st = op >= 4'd9;
        logic tmo = dly >= TO;
        valid_i = 1'b1; mem_op_i = op; addr_i = addr; store_data_i = sd; wd_i = wd; wreg_i = wr;
        wdata_i = $urandom; bus.bus_ack_i = 1'b0; bus.bus_rdata_i = $urandom;
        #1 chk("mem_stall_T", stall_o, 1);
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            chk("bus_req", bus.bus_req_o, 1);
            chk("bus_stall", stall_o, 1);
            chk("bus_valid", valid_o, 0);
            chk("bus_addr", bus.bus_addr_o, addr & ~32'h3);
            chk("bus_sel", bus.bus_sel_o, exp_sel(op, addr));
            chk("bus_we", bus.bus_we_o, st);
            chk("bus_wdata", bus.bus_wdata_o, exp_wdata(op, sd));
            if (k == dly) begin
                bus.bus_ack_i = 1'b1;
                bus.bus_rdata_i = rd;
                break;
            end
        end
        @(negedge clk);
        bus.bus_ack_i = 1'($urandom_range(0, 1));
        bus.bus_rdata_i = $urandom;
        chk("done_req", bus.bus_req_o, 0);
        chk("done_stall", stall_o, 0);
        chk("done_valid", valid_o, 1);
        chk("done_berr", bus_err_o, tmo);
        chk("done_aerr", align_err_o, 0);
        chk("done_wd", wd_o, wd);
        chk("done_wreg", wreg_o, (st || tmo) ? 1'b0 : wr);
        if (!st && !tmo) chk("done_load", wdata_o, exp_load(op, addr, rd));
        @(negedge clk);
        bus.bus_ack_i = 1'b0;
        chk("after_valid", valid_o, 0);
        chk("after_berr", bus_err_o, 0);
        chk("after_req", bus.bus_req_o, 0);
    endtask

    initial begin
        logic [3:0] ops [16] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10,
                                 4'd11, 4'd6, 4'd7, 4'd8, 4'd12, 4'd13, 4'd14, 4'd15};
        rst = 1'b1; valid_i = 1'b0; mem_op_i = '0; addr_i = '0; store_data_i = '0;
        wd_i = '0; wreg_i = 1'b0; wdata_i = '0; bus.bus_ack_i = 1'b0; bus.bus_rdata_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_stall", stall_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_wd", wd_o, 0);
        chk("rst_wreg", wreg_o, 0);
        chk("rst_wdata", wdata_o, 0);
        chk("rst_aerr", align_err_o, 0);
        chk("rst_berr", bus_err_o, 0);
        chk("rst_req", bus.bus_req_o, 0);
        chk("rst_we", bus.bus_we_o, 0);
        chk("rst_addr", bus.bus_addr_o, 0);
        chk("rst_sel", bus.bus_sel_o, 0);
        chk("rst_bwdata", bus.bus_wdata_o, 0);
        rst = 1'b0;

        none_op(1'b1, 4'd0, 5'd3, 1'b1, 32'h1111_0003);
        none_op(1'b1, 4'd0, 5'd4, 1'b1, 32'h1111_0004);
        none_op(1'b1, 4'd0, 5'd5, 1'b0, 32'h1111_0005);

        mem_op(4'd1, 32'h103, 32'h0, 32'h80AABBCC, 0, 5'd7, 1'b1);
        mem_op(4'd2, 32'h103, 32'h0, 32'h80AABBCC, 0, 5'd8, 1'b1);
        mem_op(4'd10, 32'h202, 32'h1234ABCD, 32'h0, 3, 5'd9, 1'b1);
        misal_op(4'd5, 32'h301, 5'd10);
        misal_op(4'd3, 32'h303, 5'd11);
        mem_op(4'd5, 32'h500, 32'h0, 32'hDEADBEEF, 10, 5'd12, 1'b1);
        mem_op(4'd5, 32'h504, 32'h0, 32'hCAFEF00D, TO - 1, 5'd13, 1'b1);

        valid_i = 1'b1; mem_op_i = 4'd5; addr_i = 32'h600; wd_i = 5'd14; wreg_i = 1'b1;
        bus.bus_ack_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstbus_req_before", bus.bus_req_o, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstbus_req", bus.bus_req_o, 0);
        chk("rstbus_valid", valid_o, 0);
        rst = 1'b0;
        mem_op(4'd5, 32'h600, 32'h0, 32'h0BADC0DE, 1, 5'd14, 1'b1);

        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op = ops[$urandom_range(0, 15)];
            logic        v = $urandom_range(0, 7) != 0;
            logic [31:0] addr = $urandom;
            int          n = op_size(op);
            if ($urandom_range(0, 1) == 1) addr = addr & ~32'h3;
            if (v && n != 0 && addr % n == 0)
                mem_op(op, addr, $urandom, $urandom, $urandom_range(0, 5), 5'($urandom), 1'($urandom));
            else if (v && n != 0)
                misal_op(op, addr, 5'($urandom));
            else
                none_op(v, op, 5'($urandom), 1'($urandom), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
